perceptron_weight_bank: RTL and testbench
=========================================

# perceptron_weight_bank

Parametrised weight and bias store with a training engine for an M-neuron, N-input single-layer perceptron. It sits beside the forward-evaluation datapath. It accepts one training sample per handshake, then updates one neuron per cycle through a single shared delta/multiply datapath, using signed fixed-point arithmetic with optional saturation. It also keeps sample and error statistics for convergence monitoring.

## Interface
Parameters:
- N, 8, inputs per neuron (binary x).
- M, 4, neuron (output) count.
- W, 32, signed two's-complement width of weights, bias, y, expected_y and learning_rate.
- FRAC, 0, fractional bits of learning_rate. The product is arithmetic-shifted right by FRAC.
- SAT, 1, 1 = saturate on overflow; 0 = wrap modulo 2^W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- clear  in  1  synchronous clear of weights, biases, counters; aborts any update.
- s_valid  in  1  training sample valid.
- s_ready  out  1  high only in IDLE.
- x  in  N  binary input vector.
- expected_y  in  M*W  target per neuron; neuron m at [W*m +: W].
- y  in  M*W  actual output per neuron.
- learning_rate  in  W  signed fixed-point, FRAC fraction bits.
- done  out  1  one-cycle pulse after the last neuron of a sample is written.
- weights  out  M*N*W  weight[m][i] at [W*(m*N+i) +: W].
- bias  out  M*W  bias[m] at [W*m +: W].
- sample_count  out  16  accepted samples, saturating at 16'hFFFF.
- err_count  out  16  samples with any nonzero delta, saturating.

## Operation
- FSM states: IDLE, UPDATE, DONE.
- IDLE:
  - s_ready=1.
  - If s_valid, capture x, expected_y, y and learning_rate into sample registers. Set m=0, clear the sample-error flag, increment sample_count, go to UPDATE.
- UPDATE, one neuron per cycle, index m:
  - delta = expected_y[m] − y[m], sign-extended to W+1.
  - prod = delta × learning_rate, signed 2W+1 bits.
  - adj = prod >>> FRAC.
  - bias[m] ← fit(bias[m] + adj).
  - weight[m][i] ← fit(weight[m][i] + adj) where captured x[i]=1; otherwise unchanged.
  - fit(): with SAT=1, clamp to [−2^(W−1), 2^(W−1)−1]; with SAT=0, take the low W bits.
  - If delta≠0, set the sample-error flag.
  - When m=M−1, go to DONE; otherwise m+1.
- DONE:
  - done=1.
  - Increment err_count if the error flag is set.
  - Go to IDLE.
- Neurons other than m are never written in a given cycle.
- Inputs are sampled only at acceptance; input changes while busy have no effect.
- clear (any state) and rst:
  - All weights, biases, counters and m go to 0; state goes to IDLE.
  - No done pulse. The in-flight sample is discarded.
  - If clear coincides with s_valid in IDLE, clear wins and the sample is not accepted.

## Timing
- Reset values:
  - s_ready=1 (IDLE), done=0.
  - weights, bias, sample_count and err_count all 0.
- Accept at edge T. Neuron m is written at edge T+1+m. DONE is occupied in the cycle after edge T+M, with done high in that cycle. IDLE (s_ready=1) follows one cycle later.
- Throughput: one sample per M+2 cycles. Back-to-back accept is possible in the first IDLE cycle.
- weights and bias are registered outputs. A new value is visible the cycle after its write edge.
- sample_count is visible one cycle after accept. err_count is visible one cycle after DONE.
- Counter saturation: at 16'hFFFF, increments are dropped.

## Structure
- Shared package perceptron_pkg:
  - State enum (IDLE/UPDATE/DONE).
  - Saturating-fit function parametrised on width.
  - Index helpers for flat-vector slicing.
- One sub-module, perceptron_row_update:
  - Purely combinational.
  - Takes one neuron's N weights, its bias, x, delta and learning_rate.
  - Returns the next row and a nonzero-delta flag.
  - Instantiated once and muxed by m. The top holds the FSM, sample registers, storage and counters.

## Test plan
- Basic update, N=8 M=4 W=32 FRAC=0 SAT=1, all zero after rst:
  - Stimulus: x=8'b0000_0101, expected_y[all]=1, y[all]=0, lr=2.
  - Response: done 5 cycles after accept. Every bias=2, weight[m][0]=weight[m][2]=2, others 0. sample_count=1, err_count=1.
- Zero-error sample:
  - Stimulus: expected_y=y.
  - Response: all weights unchanged, done still pulses, sample_count increments, err_count does not.
- Fractional rate, FRAC=4:
  - Stimulus: delta=−3, lr=8 (0.5).
  - Response: adj=−24>>>4=−2 applied to bias and to selected weights.
- Saturation, SAT=1 vs SAT=0:
  - Stimulus: weight preloaded near 2^31−1 via repeated updates with adj=2^30.
  - Response: SAT=1 clamps at 32'h7FFF_FFFF. SAT=0 wraps negative.
- Mid-update clear:
  - Stimulus: assert clear at T+2 during M=4 update.
  - Response: all storage 0 next cycle, no done, s_ready=1. Next sample processes normally.
- Handshake:
  - Stimulus: s_valid held high continuously.
  - Response: accepts exactly every 6 cycles. Input changes while busy never affect the stored result.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron weight bank and its row-update datapath.
// Contents: FSM state enum, width-parametrised saturating fit, flat-vector index helpers.
// No logic; purely declarations and constant-foldable functions.
package perceptron_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Widest storage word the fit helper supports, and the width of its input
  // (a W-bit operand plus a (2W+1)-bit adjustment needs 2W+2 bits).
  localparam int FIT_MAX_W = 64;
  localparam int FIT_IN_W  = 2 * FIT_MAX_W + 2;

  // Reduce a wide signed sum to w bits: clamp to the signed w-bit range when
  // sat is set, otherwise keep the low bits (modulo 2^w). The caller takes the
  // low w bits of the result.
  function automatic logic [FIT_MAX_W-1:0] sat_fit(
    input logic signed [FIT_IN_W-1:0] v,
    input int                         w,
    input logic                       sat
  );
    logic signed [FIT_IN_W-1:0] lo;
    logic signed [FIT_IN_W-1:0] hi;
    logic signed [FIT_IN_W-1:0] r;
    lo = '1;
    lo = lo <<< (w - 1);  // -2^(w-1)
    hi = ~lo;             //  2^(w-1)-1
    r  = v;
    if (sat) begin
      if (v > hi) begin
        r = hi;
      end else if (v < lo) begin
        r = lo;
      end
    end
    return r[FIT_MAX_W-1:0];
  endfunction

  // Bit offset of neuron m's first weight within the flat weight vector.
  function automatic int row_base(input int m, input int n, input int w);
    return w * m * n;
  endfunction

  // Bit offset of a per-neuron W-bit lane (bias, y, expected_y).
  function automatic int lane_base(input int m, input int w);
    return w * m;
  endfunction

endpackage

// File: rtl/perceptron_row_update.sv
// Next-state computation for one neuron's weight row and bias from a delta and learning rate.
// Latency: purely combinational. Backpressure: none; the caller decides when to write.
// Ports: row_in/bias_in current state, x selects weights to adjust, delta (W+1 signed),
//        learning_rate (W signed, FRAC fraction bits); row_out/bias_out next state, delta_nz.
module perceptron_row_update
  import perceptron_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = 32,
  parameter int FRAC = 0,
  parameter int SAT  = 1
) (
  input  logic [N*W-1:0] row_in,
  input  logic [W-1:0]   bias_in,
  input  logic [N-1:0]   x,
  input  logic [W:0]     delta,
  input  logic [W-1:0]   learning_rate,
  output logic [N*W-1:0] row_out,
  output logic [W-1:0]   bias_out,
  output logic           delta_nz
);

  localparam int PW = 2 * W + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] adj;
  logic signed [PW:0]   sum_b;
  logic signed [PW:0]   sum_w;

  always_comb begin
    prod     = PW'($signed(delta)) * PW'($signed(learning_rate));
    adj      = prod >>> FRAC;
    delta_nz = |delta;

    sum_b    = (PW+1)'($signed(bias_in)) + (PW+1)'(adj);
    bias_out = W'(sat_fit(FIT_IN_W'(sum_b), W, SAT != 0));

    sum_w    = '0;
    row_out  = row_in;
    for (int i = 0; i < N; i++) begin
      sum_w = (PW+1)'($signed(row_in[W*i +: W])) + (PW+1)'(adj);
      if (x[i]) begin
        row_out[W*i +: W] = W'(sat_fit(FIT_IN_W'(sum_w), W, SAT != 0));
      end
    end
  end

endmodule

// File: rtl/perceptron_weight_bank.sv
// Weight/bias store with a training engine updating one neuron per cycle via a shared datapath.
// Latency: accept at edge T, neuron m written at T+1+m, done pulse after T+M; one sample per M+2 cycles.
// Backpressure: s_ready is high only in IDLE; s_valid is ignored while busy or when clear is high.
// Ports: clk/rst (sync, active-high), clear; s_valid/s_ready with x, expected_y, y, learning_rate;
//        done; weights, bias, sample_count, err_count (all registered).
module perceptron_weight_bank
  import perceptron_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int W    = 32,
  parameter int FRAC = 0,
  parameter int SAT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N-1:0]     x,
  input  logic [M*W-1:0]   expected_y,
  input  logic [M*W-1:0]   y,
  input  logic [W-1:0]     learning_rate,
  output logic             done,
  output logic [M*N*W-1:0] weights,
  output logic [M*W-1:0]   bias,
  output logic [15:0]      sample_count,
  output logic [15:0]      err_count
);

  localparam int MW = (M > 1) ? $clog2(M) : 1;

  state_t           state_q;
  state_t           state_d;
  logic [MW-1:0]    m_q;
  logic [N-1:0]     x_q;
  logic [M*W-1:0]   ey_q;
  logic [M*W-1:0]   y_q;
  logic [W-1:0]     lr_q;
  logic             err_q;
  logic [M*N*W-1:0] weights_q;
  logic [M*W-1:0]   bias_q;
  logic [15:0]      sc_q;
  logic [15:0]      ec_q;

  logic             last;
  logic [W-1:0]     ey_m;
  logic [W-1:0]     y_m;
  logic [W:0]       delta;
  logic [N*W-1:0]   row_cur;
  logic [N*W-1:0]   row_nxt;
  logic [W-1:0]     bias_cur;
  logic [W-1:0]     bias_nxt;
  logic             delta_nz;

  assign last = (m_q == MW'(M - 1));

  // State register; clear aborts any in-flight sample.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_valid) state_d = UPDATE;
      UPDATE:  if (last)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_q == IDLE);
    done    = (state_q == DONE);
  end

  // Shared datapath operands for the neuron selected by m.
  always_comb begin
    ey_m     = ey_q[lane_base(int'(m_q), W) +: W];
    y_m      = y_q[lane_base(int'(m_q), W) +: W];
    delta    = {ey_m[W-1], ey_m} - {y_m[W-1], y_m};
    row_cur  = weights_q[row_base(int'(m_q), N, W) +: N*W];
    bias_cur = bias_q[lane_base(int'(m_q), W) +: W];
  end

  perceptron_row_update #(
    .N    (N),
    .W    (W),
    .FRAC (FRAC),
    .SAT  (SAT)
  ) u_row_update (
    .row_in        (row_cur),
    .bias_in       (bias_cur),
    .x             (x_q),
    .delta         (delta),
    .learning_rate (lr_q),
    .row_out       (row_nxt),
    .bias_out      (bias_nxt),
    .delta_nz      (delta_nz)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      m_q       <= '0;
      x_q       <= '0;
      ey_q      <= '0;
      y_q       <= '0;
      lr_q      <= '0;
      err_q     <= 1'b0;
      weights_q <= '0;
      bias_q    <= '0;
      sc_q      <= '0;
      ec_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            x_q   <= x;
            ey_q  <= expected_y;
            y_q   <= y;
            lr_q  <= learning_rate;
            m_q   <= '0;
            err_q <= 1'b0;
            if (sc_q != 16'hFFFF) sc_q <= sc_q + 16'd1;
          end
        end
        UPDATE: begin
          weights_q[row_base(int'(m_q), N, W) +: N*W] <= row_nxt;
          bias_q[lane_base(int'(m_q), W) +: W]       <= bias_nxt;
          err_q <= err_q | delta_nz;
          if (!last) m_q <= m_q + MW'(1);
        end
        DONE: begin
          if (err_q && (ec_q != 16'hFFFF)) ec_q <= ec_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign weights      = weights_q;
  assign bias         = bias_q;
  assign sample_count = sc_q;
  assign err_count    = ec_q;

endmodule

// File: tb/tb_perceptron_weight_bank.sv
// Bench for perceptron_weight_bank: two instances (FRAC=0/SAT=1 and FRAC=4/SAT=0) on shared stimulus.
// Expected post-sample state is pushed at acceptance and compared on the cycle after each done.
// Ports: drives all DUT inputs, observes all DUT outputs.
module tb_perceptron_weight_bank;

  localparam int N = 8;
  localparam int M = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             s_valid;
  logic [N-1:0]     x;
  logic [M*W-1:0]   ey;
  logic [M*W-1:0]   yv;
  logic [W-1:0]     lr;

  logic             s_ready0, s_ready1, done0, done1;
  logic [M*N*W-1:0] w0, w1;
  logic [M*W-1:0]   b0, b1;
  logic [15:0]      sc0, sc1, ec0, ec1;

  always #5 clk = ~clk;

  perceptron_weight_bank #(.N(N), .M(M), .W(W), .FRAC(0), .SAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_ready(s_ready0),
    .x(x), .expected_y(ey), .y(yv), .learning_rate(lr), .done(done0),
    .weights(w0), .bias(b0), .sample_count(sc0), .err_count(ec0)
  );

  perceptron_weight_bank #(.N(N), .M(M), .W(W), .FRAC(4), .SAT(0)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_ready(s_ready1),
    .x(x), .expected_y(ey), .y(yv), .learning_rate(lr), .done(done1),
    .weights(w1), .bias(b1), .sample_count(sc1), .err_count(ec1)
  );

  typedef struct {
    logic [M*N*W-1:0] w;
    logic [M*W-1:0]   b;
    logic [15:0]      sc;
    logic [15:0]      ec;
    int               acc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t pend_rec[2];
  bit   pend[2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = -1;

  int wm[2][M][N];
  int bm[2][M];
  int scm[2];
  int ecm[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int fitm(input longint v, input bit sat);
    longint hi;
    longint lo;
    hi = 2147483647;
    lo = -hi - 1;
    if (sat && v > hi) return int'(hi);
    if (sat && v < lo) return int'(lo);
    return int'(v);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < M; m++) begin
        bm[d][m] = 0;
        for (int i = 0; i < N; i++) wm[d][m][i] = 0;
      end
      scm[d] = 0;
      ecm[d] = 0;
      pend[d] = 0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic model_push(input int d, input int acc);
    exp_t   r;
    int     frac;
    bit     sat;
    bit     nz;
    int     e, yy, l;
    longint delta, adj;
    frac = (d == 0) ? 0 : 4;
    sat  = (d == 0);
    nz   = 0;
    l    = lr;
    for (int m = 0; m < M; m++) begin
      e     = ey[W*m +: W];
      yy    = yv[W*m +: W];
      delta = longint'(e) - longint'(yy);
      if (delta != 0) nz = 1;
      adj   = (delta * longint'(l)) >>> frac;
      bm[d][m] = fitm(longint'(bm[d][m]) + adj, sat);
      for (int i = 0; i < N; i++)
        if (x[i]) wm[d][m][i] = fitm(longint'(wm[d][m][i]) + adj, sat);
    end
    if (scm[d] != 65535) scm[d]++;
    if (nz && ecm[d] != 65535) ecm[d]++;
    for (int m = 0; m < M; m++) begin
      r.b[W*m +: W] = bm[d][m];
      for (int i = 0; i < N; i++) r.w[W*(m*N+i) +: W] = wm[d][m][i];
    end
    r.sc  = scm[d][15:0];
    r.ec  = ecm[d][15:0];
    r.acc = acc;
    if (d == 0) sb0.push_back(r);
    else        sb1.push_back(r);
  endtask

  task automatic mon(input int d, input logic dn, input logic [M*N*W-1:0] w,
                     input logic [M*W-1:0] b, input logic [15:0] sc, input logic [15:0] ec);
    exp_t e;
    int   qs;
    if (pend[d]) begin
      e = pend_rec[d];
      for (int m = 0; m < M; m++)
        check_eq($sformatf("d%0d_row%0d", d, m), w[m*N*W +: N*W], e.w[m*N*W +: N*W]);
      check_eq($sformatf("d%0d_bias", d), b, e.b);
      check_eq($sformatf("d%0d_sample_count", d), sc, e.sc);
      check_eq($sformatf("d%0d_err_count", d), ec, e.ec);
      pend[d] = 0;
    end
    if (dn) begin
      qs = (d == 0) ? sb0.size() : sb1.size();
      if (qs == 0) begin
        check_eq($sformatf("d%0d_spurious_done", d), dn, 0);
      end else begin
        if (d == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check_eq($sformatf("d%0d_done_latency", d), cyc - e.acc, M);
        pend_rec[d] = e;
        pend[d] = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, done0, w0, b0, sc0, ec0);
      mon(1, done1, w1, b1, sc1, ec1);
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [N-1:0] xv, input logic [M*W-1:0] ev,
                      input logic [M*W-1:0] yin, input logic [W-1:0] lv, input bit hold);
    int n;
    int acc;
    x = xv; ey = ev; yv = yin; lr = lv; s_valid = 1'b1;
    n = 0;
    while (!(s_ready0 && s_ready1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(s_ready0 && s_ready1)) begin
      check_eq("accept_timeout", s_ready0 & s_ready1, 1);
      s_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (hold && last_acc >= 0) check_eq("accept_spacing", acc - last_acc, M + 2);
    last_acc = hold ? acc : -1;
    model_push(0, acc);
    model_push(1, acc);
    @(posedge clk);
    #1;
    // Scramble inputs while busy; the stored result must not depend on them.
    x  = N'($urandom);
    ey = {$urandom, $urandom, $urandom, $urandom};
    yv = {$urandom, $urandom, $urandom, $urandom};
    lr = $urandom;
    if (!hold) s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (M + 3) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    model_clear();
    @(negedge clk);
    clear = 1'b0;
  endtask

  function automatic logic [M*W-1:0] fill(input int v);
    logic [M*W-1:0] r;
    for (int m = 0; m < M; m++) r[W*m +: W] = v;
    return r;
  endfunction

  function automatic logic [M*W-1:0] rnd_lanes();
    logic [M*W-1:0] r;
    int v;
    for (int m = 0; m < M; m++) begin
      v = int'($urandom_range(0, 2000)) - 1000;
      r[W*m +: W] = v;
    end
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M*W-1:0] ev;
    int l;
    rst = 1'b1; clear = 1'b0; s_valid = 1'b0;
    x = '0; ey = '0; yv = '0; lr = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_s_ready", s_ready0, 1);
    check_eq("rst_done", done0, 0);
    for (int m = 0; m < M; m++) check_eq("rst_weights", w0[m*N*W +: N*W], 0);
    check_eq("rst_bias", b0, 0);
    check_eq("rst_sample_count", sc0, 0);
    check_eq("rst_err_count", ec0, 0);

    // Basic update
    send(8'b0000_0101, fill(1), fill(0), 32'd2, 0);
    drain();
    check_eq("basic_bias3", b0[W*3 +: W], 32'd2);
    check_eq("basic_w00", w0[W*0 +: W], 32'd2);
    check_eq("basic_w02", w0[W*2 +: W], 32'd2);
    check_eq("basic_w01", w0[W*1 +: W], 32'd0);
    check_eq("basic_w37", w0[W*(3*N+7) +: W], 32'd0);
    check_eq("basic_sc", sc0, 16'd1);
    check_eq("basic_ec", ec0, 16'd1);
    check_eq("basic_alt_ec", ec1, 16'd1);

    // Zero-error sample
    ev = rnd_lanes();
    send(8'hA5, ev, ev, 32'd7, 0);
    drain();
    check_eq("zero_err_sc", sc0, 16'd2);
    check_eq("zero_err_ec", ec0, 16'd1);

    // Random samples
    for (int k = 0; k < 6; k++) begin
      l = int'($urandom_range(0, 128)) - 64;
      send(N'($urandom), rnd_lanes(), rnd_lanes(), l, 0);
    end
    drain();

    // s_valid held continuously
    last_acc = -1;
    for (int k = 0; k < 6; k++) begin
      l = int'($urandom_range(0, 128)) - 64;
      send(N'($urandom), rnd_lanes(), rnd_lanes(), l, 1);
    end
    s_valid = 1'b0;
    last_acc = -1;
    drain();

    // Clear in the middle of an update: no done, everything zero
    send(8'hFF, fill(5), fill(1), 32'd3, 0);
    @(negedge clk);
    pulse_clear();
    for (int m = 0; m < M; m++) check_eq("clr_weights", w0[m*N*W +: N*W], 0);
    check_eq("clr_bias", b0, 0);
    check_eq("clr_sc", sc0, 0);
    check_eq("clr_ec", ec0, 0);
    check_eq("clr_s_ready", s_ready0, 1);
    drain();
    send(8'h0F, fill(2), fill(0), 32'd1, 0);
    drain();
    check_eq("post_clr_sc", sc0, 16'd1);

    // clear wins over a coincident s_valid in IDLE
    x = 8'hFF; ey = fill(9); yv = fill(0); lr = 32'd1;
    s_valid = 1'b1;
    pulse_clear();
    s_valid = 1'b0;
    check_eq("clr_vs_valid_sc", sc0, 0);
    check_eq("clr_vs_valid_ready", s_ready0, 1);
    drain();

    // Fractional rate: delta=-3, lr=8
    send(8'hFF, fill(0), fill(3), 32'd8, 0);
    drain();
    check_eq("frac0_bias0", b0[W*0 +: W], 32'hFFFF_FFE8);
    check_eq("frac4_bias0", b1[W*0 +: W], 32'hFFFF_FFFE);
    check_eq("frac4_w07", w1[W*7 +: W], 32'hFFFF_FFFE);

    // Saturation vs wrap with adj=2^30 (2^26 on the FRAC=4 instance)
    pulse_clear();
    last_acc = -1;
    for (int k = 0; k < 34; k++) send(8'hFF, fill(1), fill(0), 32'h4000_0000, 1);
    s_valid = 1'b0;
    last_acc = -1;
    drain();
    check_eq("sat_w00", w0[W*0 +: W], 32'h7FFF_FFFF);
    check_eq("sat_bias2", b0[W*2 +: W], 32'h7FFF_FFFF);
    check_eq("wrap_w00", w1[W*0 +: W], 32'h8800_0000);
    check_eq("sat_sc", sc0, 16'd34);

    check_eq("sb0_drained", sb0.size(), 0);
    check_eq("sb1_drained", sb1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
